multi_ch_vector_accum_invoke: RTL and testbench
===============================================

# multi_ch_vector_accum_invoke

Parametrised CFDF actor invoke module for the stream-computation datapath, next generation of the single-channel invoke/firing FSM pair. One flat multi-state FSM with per-mode firing behaviour:
- **READ** consumes a length token L, then L tokens from each of NCH data FIFOs, accumulating per channel.
- **COMPUTE** finds the channel with the largest accumulator.
- **WRITE** emits all accumulators plus the winning index.

It sits between the LWDF-V scheduler (invoke/FC/next_mode handshake) and its FIFOs. The scheduler has already checked enable conditions (token and space counts) before invoking.

## Interface
- WIDTH, 10, bit width of data and length tokens
- NCH, 4, number of input data channels (2..16)
- MAX_LEN, 16, largest legal L
- ACC_W, 14, accumulator and result width; must satisfy ACC_W ≥ WIDTH+clog2(MAX_LEN) and ACC_W ≥ clog2(NCH)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- invoke  in  1  scheduler firing request, sampled only in IDLE
- next_mode_in  in  2  mode to fire: 00 READ, 01 COMPUTE, 10 WRITE, 11 illegal
- data_in_fifo  in  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- rd_data_in_fifo  out  NCH  per-channel read enable
- length_in_fifo  in  WIDTH  length FIFO head
- rd_length_in_fifo  out  1  length FIFO read enable
- wr_out_fifo  out  1  output FIFO write enable
- result_out  out  ACC_W  output token; 0 whenever wr_out_fifo=0
- next_mode_out  out  2  mode for next firing, valid while FC=1
- FC  out  1  firing complete, one-cycle pulse
- busy  out  1  high in every state except IDLE
- err  out  1  one-cycle pulse with FC on an illegal length or mode

## Operation
- **FIFO read protocol:** rd asserted in cycle t gives valid data in cycle t+1. Reads and writes are single-cycle pulses. All arithmetic is unsigned, modulo 2^ACC_W.
- **States:** IDLE, RD_LEN, LATCH_LEN, RD_DATA, TAIL, SCAN, WRITE, DONE.
- **IDLE:**
  - invoke=1 with next_mode_in=00 goes to RD_LEN.
  - 01 goes to SCAN.
  - 10 goes to WRITE.
  - 11 goes to DONE with err=1 and next_mode_out=00.
  - Invoke while busy=1 is ignored; it is not queued.
- **RD_LEN:** rd_length_in_fifo=1, then LATCH_LEN.
- **LATCH_LEN:** capture L.
  - If L=0 or L>MAX_LEN: go to DONE with err=1 and next_mode_out=00. Accumulators and data FIFOs are untouched.
  - Else: clear all accumulators and the beat counter, then go to RD_DATA.
- **RD_DATA:** rd_data_in_fifo=all ones for exactly L consecutive cycles.
  - In each cycle after a read, acc[c] += data_in_fifo[c] for every c.
  - After the L-th read, go to TAIL, which performs the last accumulate.
  - Then DONE with next_mode_out=01.
- **SCAN:** NCH cycles, one channel index per cycle (0..NCH-1).
  - Track max_val and max_idx. Replace the running maximum only on strictly greater, so ties keep the lowest index.
  - Then DONE with next_mode_out=10.
- **WRITE:** NCH+1 consecutive cycles with wr_out_fifo=1.
  - result_out = acc[0]..acc[NCH-1], then max_idx zero-extended.
  - Then clear accumulators, max_val and max_idx, and go to DONE with next_mode_out=00.
- **DONE:** FC=1 for one cycle, then IDLE.
- Firing WRITE before SCAN is legal and emits the current register contents.
- **Reset (any time, including mid-firing):**
  - Immediately: state IDLE; all outputs 0 (next_mode_out=00, FC=0, busy=0, err=0, all enables 0, result_out=0).
  - Accumulators, L, max_val, max_idx and counters go to 0.
  - Any partially consumed tokens are lost; this is the scheduler's responsibility.

## Timing
- Cycle 0 is the edge on which invoke is sampled in IDLE.
- **READ, legal L:**
  - rd_length_in_fifo in cycle 1.
  - rd_data in cycles 3..L+2.
  - Accumulates in cycles 4..L+3.
  - FC in cycle L+4.
  - Back in IDLE at L+5, so a new invoke is accepted at cycle L+5.
- **READ, illegal L:** FC and err in cycle 3.
- **COMPUTE:** SCAN in cycles 1..NCH, FC in cycle NCH+1.
- **WRITE:** wr_out_fifo in cycles 1..NCH+1, FC in cycle NCH+2.
- **Illegal mode:** FC and err in cycle 1.
- All outputs are decoded from registered state and counters. There is no combinational path from the inputs to FC, busy or any enable.

## Test plan
- **Reset values:** assert rst low mid-RD_DATA (async, between edges). Required: all outputs 0 immediately. A following READ invoke with L=3 restarts cleanly, FC in cycle 7.
- **Full READ→COMPUTE→WRITE sequence:** NCH=4, L=3, channel data ch0={1,2,3}, ch1={10,0,0}, ch2={4,4,4}, ch3={0,0,7}. Required:
  - READ FC at cycle 7, next_mode_out=01.
  - COMPUTE FC at cycle 5, next_mode_out=10.
  - WRITE outputs 6,10,12,7,2 in cycles 1..5, FC at cycle 6, next_mode_out=00.
- **Tie on maximum:** all channels accumulate 5. Required: max index token = 0.
- **Illegal length:** L=0, then L=17 (MAX_LEN=16). Required in each case: FC+err at cycle 3, next_mode_out=00, rd_data_in_fifo never asserted, accumulators unchanged.
- **Illegal mode and busy invoke:** next_mode_in=11 gives FC+err at cycle 1. Invoke held high through a READ firing gives exactly one firing, with no extra rd pulses.
- **Wraparound:** ACC_W=14, L=16, all data 1023 on ch0. Required: acc[0]=16368 exactly. With override ACC_W=12, the same stimulus gives 16368 mod 4096 = 4080.

Source files
------------

// File: rtl/multi_ch_vector_accum_invoke.sv
// Multi-channel vector accumulate actor invoke FSM.
// READ accumulates L tokens per channel, COMPUTE finds the largest accumulator,
// WRITE emits every accumulator followed by the winning channel index.
module multi_ch_vector_accum_invoke #(
  parameter int unsigned WIDTH   = 10,
  parameter int unsigned NCH     = 4,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned ACC_W   = 14
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   invoke,
  input  logic [1:0]             next_mode_in,
  input  logic [NCH*WIDTH-1:0]   data_in_fifo,
  output logic [NCH-1:0]         rd_data_in_fifo,
  input  logic [WIDTH-1:0]       length_in_fifo,
  output logic                   rd_length_in_fifo,
  output logic                   wr_out_fifo,
  output logic [ACC_W-1:0]       result_out,
  output logic [1:0]             next_mode_out,
  output logic                   FC,
  output logic                   busy,
  output logic                   err
);

  // Counter is wide enough for any WIDTH-bit length and for NCH+1 write beats.
  localparam int unsigned CW = WIDTH + 5;
  localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [2:0] {
    StIdle, StRdLen, StLatchLen, StRdData, StTail, StScan, StWrite, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   len_q, len_d;
  logic [ACC_W-1:0]   acc_q [NCH];
  logic [ACC_W-1:0]   acc_d [NCH];
  logic [ACC_W-1:0]   max_val_q, max_val_d;
  logic [IW-1:0]      max_idx_q, max_idx_d;
  logic [1:0]         nm_q, nm_d;
  logic               err_q, err_d;
  logic [ACC_W-1:0]   sel_acc;
  logic               acc_en;

  // Accumulator selected by the beat counter (scan index or write beat).
  always_comb begin
    sel_acc = '0;
    for (int c = 0; c < NCH; c++) begin
      if (cnt_q == CW'(c)) sel_acc = acc_q[c];
    end
  end

  // Data from a read issued last cycle is on the FIFO heads now.
  assign acc_en = ((state_q == StRdData) && (cnt_q != '0)) || (state_q == StTail);

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    acc_d     = acc_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    nm_d      = nm_q;
    err_d     = err_q;

    if (acc_en) begin
      for (int c = 0; c < NCH; c++) begin
        acc_d[c] = acc_q[c] + ACC_W'(data_in_fifo[c*WIDTH +: WIDTH]);
      end
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (invoke) begin
          unique case (next_mode_in)
            2'b00:   state_d = StRdLen;
            2'b01:   state_d = StScan;
            2'b10:   state_d = StWrite;
            default: begin
              state_d = StDone;
              err_d   = 1'b1;
              nm_d    = 2'b00;
            end
          endcase
        end
      end
      StRdLen: state_d = StLatchLen;
      StLatchLen: begin
        len_d = length_in_fifo;
        if ((length_in_fifo == '0) || ({5'b0, length_in_fifo} > CW'(MAX_LEN))) begin
          state_d = StDone;
          err_d   = 1'b1;
          nm_d    = 2'b00;
        end else begin
          for (int c = 0; c < NCH; c++) acc_d[c] = '0;
          cnt_d   = '0;
          state_d = StRdData;
        end
      end
      StRdData: begin
        cnt_d = cnt_q + CW'(1);
        if ((cnt_q + CW'(1)) == {5'b0, len_q}) state_d = StTail;
      end
      StTail: begin
        state_d = StDone;
        nm_d    = 2'b01;
      end
      StScan: begin
        // Index 0 seeds the running max; later ones replace only on strictly greater.
        if ((cnt_q == '0) || (sel_acc > max_val_q)) begin
          max_val_d = sel_acc;
          max_idx_d = cnt_q[IW-1:0];
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NCH - 1)) begin
          state_d = StDone;
          nm_d    = 2'b10;
        end
      end
      StWrite: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(NCH)) begin
          for (int c = 0; c < NCH; c++) acc_d[c] = '0;
          max_val_d = '0;
          max_idx_d = '0;
          state_d   = StDone;
          nm_d      = 2'b00;
        end
      end
      StDone: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len_q     <= '0;
      max_val_q <= '0;
      max_idx_q <= '0;
      nm_q      <= 2'b00;
      err_q     <= 1'b0;
      for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
      nm_q      <= nm_d;
      err_q     <= err_d;
      for (int c = 0; c < NCH; c++) acc_q[c] <= acc_d[c];
    end
  end

  // Outputs decoded purely from registered state, so reset clears them at once.
  always_comb begin
    rd_length_in_fifo = (state_q == StRdLen);
    rd_data_in_fifo   = {NCH{state_q == StRdData}};
    wr_out_fifo       = (state_q == StWrite);
    FC                = (state_q == StDone);
    busy              = (state_q != StIdle);
    err               = FC & err_q;
    next_mode_out     = FC ? nm_q : 2'b00;
    result_out        = '0;
    if (wr_out_fifo) begin
      result_out = (cnt_q == CW'(NCH)) ? ACC_W'(max_idx_q) : sel_acc;
    end
  end

endmodule

// File: tb/tb_multi_ch_vector_accum_invoke.sv
// Scoreboard bench for multi_ch_vector_accum_invoke: stimulus pushes expected FC and
// output tokens, a negedge monitor pops and compares whenever the DUT presents them.
module tb_multi_ch_vector_accum_invoke;

  localparam int WIDTH   = 10;
  localparam int NCH     = 4;
  localparam int MAX_LEN = 16;
  localparam int ACC_W   = 14;

  logic                 clk;
  logic                 rst;
  logic                 invoke;
  logic [1:0]           next_mode_in;
  logic [NCH*WIDTH-1:0] data_head;
  logic [WIDTH-1:0]     len_head;
  logic [NCH-1:0]       rd_data_in_fifo;
  logic                 rd_length_in_fifo;
  logic                 wr_out_fifo;
  logic [ACC_W-1:0]     result_out;
  logic [1:0]           next_mode_out;
  logic                 FC, busy, err;

  // Second instance with a narrow accumulator for the wraparound case.
  logic [NCH-1:0] w2_rd_data;
  logic           w2_rd_len, w2_wr, w2_fc, w2_busy, w2_err;
  logic [11:0]    w2_result;
  logic [1:0]     w2_nm;

  multi_ch_vector_accum_invoke #(
    .WIDTH(WIDTH), .NCH(NCH), .MAX_LEN(MAX_LEN), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst(rst), .invoke(invoke), .next_mode_in(next_mode_in),
    .data_in_fifo(data_head), .rd_data_in_fifo(rd_data_in_fifo),
    .length_in_fifo(len_head), .rd_length_in_fifo(rd_length_in_fifo),
    .wr_out_fifo(wr_out_fifo), .result_out(result_out), .next_mode_out(next_mode_out),
    .FC(FC), .busy(busy), .err(err)
  );

  multi_ch_vector_accum_invoke #(
    .WIDTH(WIDTH), .NCH(NCH), .MAX_LEN(MAX_LEN), .ACC_W(12)
  ) dut12 (
    .clk(clk), .rst(rst), .invoke(invoke), .next_mode_in(next_mode_in),
    .data_in_fifo(data_head), .rd_data_in_fifo(w2_rd_data),
    .length_in_fifo(len_head), .rd_length_in_fifo(w2_rd_len),
    .wr_out_fifo(w2_wr), .result_out(w2_result), .next_mode_out(w2_nm),
    .FC(w2_fc), .busy(w2_busy), .err(w2_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] nm;
    logic       er;
    int         cyc;
  } fc_item_t;

  typedef struct {
    logic [ACC_W-1:0] val;
    int               cyc;
  } wr_item_t;

  fc_item_t             fc_q[$];
  wr_item_t             wr_q[$];
  logic [11:0]          wr2_q[$];
  logic [WIDTH-1:0]     lenq[$];
  logic [NCH*WIDTH-1:0] datq[$];
  logic [ACC_W-1:0]     wexp [NCH+1];

  int cyc = 0;
  int n_rdlen = 0;
  int n_rddata = 0;
  int checks = 0;
  int errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO model: a read pulse in cycle t presents the next token in cycle t+1.
  always @(posedge clk) begin
    if (rd_length_in_fifo) begin
      n_rdlen <= n_rdlen + 1;
      if (lenq.size() > 0) len_head <= lenq.pop_front();
      else len_head <= '0;
    end
    if (|rd_data_in_fifo) begin
      n_rddata <= n_rddata + 1;
      if (datq.size() > 0) data_head <= datq.pop_front();
      else data_head <= '0;
    end
  end

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    if (rst) begin
      if (FC) begin
        if (fc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fc: got FC=1 at cycle %0d, expected none", cyc);
        end else begin
          fc_item_t it;
          it = fc_q.pop_front();
          chk("fc_cycle", cyc, it.cyc);
          chk("fc_next_mode", next_mode_out, it.nm);
          chk("fc_err", err, it.er);
        end
      end else begin
        chk("err_outside_fc", err, 0);
      end
      if (wr_out_fifo) begin
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wr: got token %0d at cycle %0d, expected none",
                   result_out, cyc);
        end else begin
          wr_item_t w;
          w = wr_q.pop_front();
          chk("wr_value", result_out, w.val);
          chk("wr_cycle", cyc, w.cyc);
        end
      end else begin
        chk("result_zero_when_idle", result_out, 0);
      end
      if (w2_wr) begin
        if (wr2_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wr12: got token %0d, expected none", w2_result);
        end else begin
          chk("wr12_value", w2_result, wr2_q.pop_front());
        end
      end
    end
  end

  function automatic logic [NCH*WIDTH-1:0] word(input int a, input int b, input int c,
                                                input int d);
    return {WIDTH'(d), WIDTH'(c), WIDTH'(b), WIDTH'(a)};
  endfunction

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still 1, expected 0 within 200 cycles");
    end
  endtask

  // Issue one firing; expected FC (and write tokens) are queued with absolute cycles.
  task automatic fire(input logic [1:0] mode, input int fc_k, input logic [1:0] nm,
                      input logic er, input bit hold, input bit is_wr);
    int       t0;
    bit       seen;
    fc_item_t it;
    wr_item_t w;
    @(negedge clk);
    t0 = cyc;
    it.nm = nm;
    it.er = er;
    it.cyc = t0 + fc_k;
    fc_q.push_back(it);
    if (is_wr) begin
      for (int i = 0; i <= NCH; i++) begin
        w.val = wexp[i];
        w.cyc = t0 + 1 + i;
        wr_q.push_back(w);
        wr2_q.push_back(wexp[i][11:0]);
      end
    end
    invoke = 1'b1;
    next_mode_in = mode;
    if (hold) begin
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (FC) seen = 1'b1;
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL fc_timeout: got no FC, expected FC within 100 cycles");
      end
    end else begin
      @(negedge clk);
    end
    invoke = 1'b0;
    next_mode_in = 2'b00;
    wait_idle();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_FC"}, FC, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rd_len"}, rd_length_in_fifo, 0);
    chk({tag, "_rd_data"}, rd_data_in_fifo, 0);
    chk({tag, "_wr"}, wr_out_fifo, 0);
    chk({tag, "_result"}, result_out, 0);
    chk({tag, "_next_mode"}, next_mode_out, 0);
  endtask

  initial begin
    int l0, d0;
    rst = 1'b0;
    invoke = 1'b0;
    next_mode_in = 2'b00;
    data_head = '0;
    len_head = '0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b1;

    // Illegal mode: FC+err in cycle 1.
    fire(2'b11, 1, 2'b00, 1'b1, 1'b0, 1'b0);

    // WRITE straight out of reset emits the cleared registers.
    for (int i = 0; i <= NCH; i++) wexp[i] = '0;
    fire(2'b10, NCH + 2, 2'b00, 1'b0, 1'b0, 1'b1);

    // Abort a READ with an asynchronous reset in the middle of RD_DATA.
    lenq.push_back(WIDTH'(3));
    for (int i = 0; i < 3; i++) datq.push_back(word(9, 9, 9, 9));
    @(negedge clk);
    invoke = 1'b1;
    next_mode_in = 2'b00;
    @(negedge clk);
    invoke = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_rd_data_active", rd_data_in_fifo, 4'hf);
    #2 rst = 1'b0;
    #1 chk_outputs_zero("async_reset");
    lenq.delete();
    datq.delete();
    @(negedge clk);
    rst = 1'b1;

    // Full sequence; invoke is held high through the READ firing.
    lenq.push_back(WIDTH'(3));
    datq.push_back(word(1, 10, 4, 0));
    datq.push_back(word(2, 0, 4, 0));
    datq.push_back(word(3, 0, 4, 7));
    l0 = n_rdlen;
    d0 = n_rddata;
    fire(2'b00, 7, 2'b01, 1'b0, 1'b1, 1'b0);
    chk("held_invoke_rd_len_pulses", n_rdlen - l0, 1);
    chk("held_invoke_rd_data_pulses", n_rddata - d0, 3);
    fire(2'b01, NCH + 1, 2'b10, 1'b0, 1'b0, 1'b0);
    wexp[0] = 6; wexp[1] = 10; wexp[2] = 12; wexp[3] = 7; wexp[4] = 2;
    fire(2'b10, NCH + 2, 2'b00, 1'b0, 1'b0, 1'b1);

    // Tie on the maximum keeps the lowest index.
    lenq.push_back(WIDTH'(1));
    datq.push_back(word(5, 5, 5, 5));
    fire(2'b00, 5, 2'b01, 1'b0, 1'b0, 1'b0);
    fire(2'b01, NCH + 1, 2'b10, 1'b0, 1'b0, 1'b0);
    wexp[0] = 5; wexp[1] = 5; wexp[2] = 5; wexp[3] = 5; wexp[4] = 0;
    fire(2'b10, NCH + 2, 2'b00, 1'b0, 1'b0, 1'b1);

    // Illegal lengths must leave accumulators 3,6,4,4 untouched.
    lenq.push_back(WIDTH'(2));
    datq.push_back(word(1, 3, 0, 2));
    datq.push_back(word(2, 3, 4, 2));
    fire(2'b00, 6, 2'b01, 1'b0, 1'b0, 1'b0);
    foreach (lenq[i]) ;
    for (int k = 0; k < 2; k++) begin
      lenq.push_back((k == 0) ? WIDTH'(0) : WIDTH'(MAX_LEN + 1));
      l0 = n_rdlen;
      d0 = n_rddata;
      fire(2'b00, 3, 2'b00, 1'b1, 1'b0, 1'b0);
      chk("bad_len_rd_len_pulses", n_rdlen - l0, 1);
      chk("bad_len_rd_data_pulses", n_rddata - d0, 0);
    end
    wexp[0] = 3; wexp[1] = 6; wexp[2] = 4; wexp[3] = 4; wexp[4] = 0;
    fire(2'b10, NCH + 2, 2'b00, 1'b0, 1'b0, 1'b1);

    // Wraparound: 16 x 1023 is 16368; the 12-bit instance sees 4080.
    lenq.push_back(WIDTH'(16));
    for (int i = 0; i < 16; i++) datq.push_back(word(1023, 0, 0, 0));
    fire(2'b00, 20, 2'b01, 1'b0, 1'b0, 1'b0);
    wexp[0] = 16368; wexp[1] = 0; wexp[2] = 0; wexp[3] = 0; wexp[4] = 0;
    fire(2'b10, NCH + 2, 2'b00, 1'b0, 1'b0, 1'b1);

    repeat (4) @(negedge clk);
    chk("pending_fc_events", fc_q.size(), 0);
    chk("pending_wr_tokens", wr_q.size(), 0);
    chk("pending_wr12_tokens", wr2_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
